// File: rtl/lagarto_pmu_pkg.sv
// Shared types for the Lagarto PMU counter bank: CSR classes, event indices, control layout.
// Event indices follow the order of the core's io_core_pmu_* outputs.
package lagarto_pmu_pkg;

  localparam int PMU_CSR_DW  = 64;
  localparam int PMU_IDX_W   = 5;

  typedef enum logic [1:0] {
    CNT    = 2'd0,
    EVTSEL = 2'd1,
    CTRL   = 2'd2,
    OVF    = 2'd3
  } pmu_csr_class_e;

  typedef enum logic [4:0] {
    PMU_EVT_CYCLES          = 5'd0,
    PMU_EVT_NEW_FETCH       = 5'd1,
    PMU_EVT_ICACHE_REQ      = 5'd2,
    PMU_EVT_ICACHE_KILL     = 5'd3,
    PMU_EVT_STALL_IF        = 5'd4,
    PMU_EVT_STALL_ID        = 5'd5,
    PMU_EVT_STALL_RR        = 5'd6,
    PMU_EVT_STALL_EXE       = 5'd7,
    PMU_EVT_STALL_WB        = 5'd8,
    PMU_EVT_BUFFER_MISS     = 5'd9,
    PMU_EVT_IMISS_KILL      = 5'd10,
    PMU_EVT_ICACHE_BUSSY    = 5'd11,
    PMU_EVT_IMISS_TIME      = 5'd12,
    PMU_EVT_LOAD_STORE      = 5'd13,
    PMU_EVT_DATA_DEPEND     = 5'd14,
    PMU_EVT_STRUCT_DEPEND   = 5'd15,
    PMU_EVT_GRAD_LIST_FULL  = 5'd16,
    PMU_EVT_FREE_LIST_EMPTY = 5'd17,
    PMU_EVT_ITLB_ACCESS     = 5'd18,
    PMU_EVT_ITLB_MISS       = 5'd19,
    PMU_EVT_DTLB_ACCESS     = 5'd20,
    PMU_EVT_DTLB_MISS       = 5'd21,
    PMU_EVT_PTW_BUFFER_HIT  = 5'd22,
    PMU_EVT_PTW_BUFFER_MISS = 5'd23,
    PMU_EVT_ITLB_STALL      = 5'd24
  } pmu_evt_e;

  // Read/written as one word: enable in bit 0, inhibit mask above it.
  typedef struct packed {
    logic [31:0] inhibit;
    logic        enable;
  } pmu_ctrl_t;

endpackage

// File: rtl/lagarto_pmu_counter_bank_if.sv
// CSR access port of the PMU counter bank; master = CSR/debug logic, slave = counter bank.
interface lagarto_pmu_counter_bank_if;
  import lagarto_pmu_pkg::*;

  // req is accepted every cycle it is high (no ready); a read (req & ~we) is answered
  // on the next cycle by a one-cycle rvalid pulse with rdata valid alongside it.
  logic                  req;
  logic                  we;
  pmu_csr_class_e        cls;
  logic [PMU_IDX_W-1:0]  idx;
  logic [PMU_CSR_DW-1:0] wdata;
  logic [PMU_CSR_DW-1:0] rdata;
  logic                  rvalid;

  modport master (output req, we, cls, idx, wdata, input rdata, rvalid);
  modport slave  (input req, we, cls, idx, wdata, output rdata, rvalid);

endinterface

// File: rtl/lagarto_pmu_counter.sv
// Single PMU counter: CSR write beats increment; wrap pulses when all-ones is incremented.
module lagarto_pmu_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc,
  input  logic                 wr_en,
  input  logic [CNT_WIDTH-1:0] wr_data,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 wrap
);

  assign wrap = inc & ~wr_en & (&value);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value <= '0;
    end else if (wr_en) begin
      value <= wr_data;
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/lagarto_pmu_counter_bank.sv
// Lagarto PMU counter bank: registered event vector, per-counter event select, CSR port.
// Optional overflow status/interrupt is enabled by defining LAGARTO_PMU_OVF_IRQ_EN.
module lagarto_pmu_counter_bank
  import lagarto_pmu_pkg::*;
#(
  parameter int NUM_EVENTS   = 25,
  parameter int NUM_COUNTERS = 8,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_EVENTS-1:0]       pmu_sig_i,
  lagarto_pmu_counter_bank_if.slave   csr,
  output logic                        ovf_irq_o
);

  localparam int SEL_WIDTH = $clog2(NUM_EVENTS);
  localparam int SEL_SPAN  = 1 << SEL_WIDTH;
  localparam logic [31:0] INH_MASK = 32'((64'd1 << NUM_COUNTERS) - 64'd1);

  logic [NUM_EVENTS-1:0]   evt_q;
  logic [SEL_SPAN-1:0]     evt_pad;
  logic [SEL_WIDTH-1:0]    evtsel [NUM_COUNTERS];
  pmu_ctrl_t               ctrl;
  logic [NUM_COUNTERS-1:0] inc;
  logic [NUM_COUNTERS-1:0] cnt_wr;
  logic [NUM_COUNTERS-1:0] wrap;
  logic [CNT_WIDTH-1:0]    cnt_val [NUM_COUNTERS];
  logic                    rd_req;
  logic                    wr_req;
  logic [63:0]             rd_mux;
  logic [63:0]             ovf_rd;
  logic [63:0]             rdata_q;
  logic                    rvalid_q;

  assign rd_req = csr.req & ~csr.we;
  assign wr_req = csr.req & csr.we;

  // Selectors beyond NUM_EVENTS land on the zero padding and never count.
  always_comb begin
    evt_pad = '0;
    evt_pad[NUM_EVENTS-1:0] = evt_q;
  end

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
    assign cnt_wr[g] = wr_req & (csr.cls == CNT) & (csr.idx == 5'(g));
    assign inc[g]    = ctrl.enable & ~ctrl.inhibit[g] & evt_pad[evtsel[g]];

    lagarto_pmu_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc     (inc[g]),
      .wr_en   (cnt_wr[g]),
      .wr_data (csr.wdata[CNT_WIDTH-1:0]),
      .value   (cnt_val[g]),
      .wrap    (wrap[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q <= '0;
      ctrl  <= '{inhibit: '0, enable: 1'b1};
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        evtsel[i] <= SEL_WIDTH'(i % NUM_EVENTS);
      end
    end else begin
      evt_q <= pmu_sig_i;
      if (wr_req && csr.cls == CTRL) begin
        ctrl.enable  <= csr.wdata[0];
        ctrl.inhibit <= csr.wdata[32:1] & INH_MASK;
      end
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (wr_req && csr.cls == EVTSEL && csr.idx == 5'(i)) begin
          evtsel[i] <= csr.wdata[SEL_WIDTH-1:0];
        end
      end
    end
  end

`ifdef LAGARTO_PMU_OVF_IRQ_EN
  logic [NUM_COUNTERS-1:0] ovf;
  logic [NUM_COUNTERS-1:0] irq_mask;
  logic [NUM_COUNTERS-1:0] ovf_clr;
  logic                    irq_q;

  assign ovf_clr = (wr_req && csr.cls == OVF) ? csr.wdata[NUM_COUNTERS-1:0] : '0;

  // A wrap in the same cycle as its W1C clear keeps the bit set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf      <= '0;
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      ovf   <= (ovf & ~ovf_clr) | wrap;
      irq_q <= |(ovf & irq_mask);
      if (wr_req && csr.cls == OVF) begin
        irq_mask <= csr.wdata[32 +: NUM_COUNTERS];
      end
    end
  end

  assign ovf_rd    = {32'(irq_mask), 32'(ovf)};
  assign ovf_irq_o = irq_q;
`else
  logic unused_wrap;
  assign unused_wrap = |wrap;
  assign ovf_rd      = '0;
  assign ovf_irq_o   = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (csr.cls)
      CNT: begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          if (csr.idx == 5'(i)) rd_mux = 64'(cnt_val[i]);
        end
      end
      EVTSEL: begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          if (csr.idx == 5'(i)) rd_mux = 64'(evtsel[i]);
        end
      end
      CTRL:    rd_mux = 64'(ctrl);
      OVF:     rd_mux = ovf_rd;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_req;
      if (rd_req) rdata_q <= rd_mux;
    end
  end

  assign csr.rdata  = rdata_q;
  assign csr.rvalid = rvalid_q;

endmodule

// File: tb/tb_lagarto_pmu_counter_bank.sv
// Randomised bench for lagarto_pmu_counter_bank (8-bit counters) against a cycle-level model.
// Expectations for class 3 and the interrupt follow LAGARTO_PMU_OVF_IRQ_EN.
module tb_lagarto_pmu_counter_bank;
  import lagarto_pmu_pkg::*;

  localparam int NE = 25;
  localparam int NC = 8;
  localparam int CW = 8;
`ifdef LAGARTO_PMU_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NE-1:0] pmu = '0;
  logic          irq;

  lagarto_pmu_counter_bank_if csr_bus();

  lagarto_pmu_counter_bank #(
    .NUM_EVENTS   (NE),
    .NUM_COUNTERS (NC),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pmu_sig_i (pmu),
    .csr       (csr_bus),
    .ovf_irq_o (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: architectural state, advanced once per clock edge.
  logic [7:0]    m_cnt [NC];
  logic [4:0]    m_sel [NC];
  bit            m_en;
  logic [7:0]    m_inh;
  logic [7:0]    m_ovf;
  logic [7:0]    m_mask;
  bit            m_irq;
  logic [NE-1:0] m_evt;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 8'd0;
      m_sel[i] = 5'(i % NE);
    end
    m_en = 1'b1; m_inh = '0; m_ovf = '0; m_mask = '0; m_irq = 1'b0; m_evt = '0;
  endtask

  function automatic logic [63:0] model_read(input bit [1:0] c, input bit [4:0] ix);
    if (c == 2'd0) return (ix < NC) ? 64'(m_cnt[ix[2:0]]) : 64'd0;
    if (c == 2'd1) return (ix < NC) ? 64'(m_sel[ix[2:0]]) : 64'd0;
    if (c == 2'd2) return {55'd0, m_inh, m_en};
    return OVF_EN ? {24'd0, m_mask, 24'd0, m_ovf} : 64'd0;
  endfunction

  task automatic model_step(input bit rq, input bit w, input bit [1:0] c, input bit [4:0] ix,
                            input logic [63:0] wd, input logic [NE-1:0] p);
    logic [7:0] wraps = '0;
    for (int i = 0; i < NC; i++) begin
      if (rq && w && c == 2'd0 && ix == 5'(i)) begin
        m_cnt[i] = wd[7:0];
      end else if (m_en && !m_inh[i] && m_sel[i] < NE && m_evt[m_sel[i]]) begin
        m_cnt[i] = m_cnt[i] + 8'd1;
        if (m_cnt[i] == 8'd0) wraps[i] = 1'b1;
      end
    end
    if (OVF_EN) begin
      m_irq = |(m_ovf & m_mask);
      if (rq && w && c == 2'd3) begin
        m_ovf  = m_ovf & ~wd[7:0];
        m_mask = wd[39:32];
      end
      m_ovf = m_ovf | wraps;
    end else begin
      m_irq = 1'b0;
    end
    if (rq && w && c == 2'd1 && ix < NC) m_sel[ix[2:0]] = wd[4:0];
    if (rq && w && c == 2'd2) begin
      m_en  = wd[0];
      m_inh = wd[8:1];
    end
    m_evt = p;
  endtask

  // One clock: drive inputs, advance the model, check outputs 1 time unit after the edge.
  task automatic tick(input string tag, input logic [NE-1:0] p, input bit rq, input bit w,
                      input bit [1:0] c, input bit [4:0] ix, input logic [63:0] wd,
                      output logic [63:0] rd);
    logic [63:0] exp_rd;
    bit          is_rd;
    pmu           = p;
    csr_bus.req   = rq;
    csr_bus.we    = w;
    csr_bus.cls   = pmu_csr_class_e'(c);
    csr_bus.idx   = ix;
    csr_bus.wdata = wd;
    is_rd  = rq && !w;
    exp_rd = model_read(c, ix);
    model_step(rq, w, c, ix, wd, p);
    @(posedge clk);
    #1;
    check({tag, "_rvalid"}, 64'(csr_bus.rvalid), 64'(is_rd));
    rd = csr_bus.rdata;
    if (is_rd) check({tag, "_rdata"}, csr_bus.rdata, exp_rd);
    check({tag, "_irq"}, 64'(irq), 64'(m_irq));
  endtask

  task automatic idle(input string tag, input logic [NE-1:0] p, input int n);
    logic [63:0] d;
    repeat (n) tick(tag, p, 1'b0, 1'b0, 2'd0, 5'd0, 64'd0, d);
  endtask

  task automatic csr_wr(input string tag, input bit [1:0] c, input bit [4:0] ix,
                        input logic [63:0] wd, input logic [NE-1:0] p);
    logic [63:0] d;
    tick(tag, p, 1'b1, 1'b1, c, ix, wd, d);
  endtask

  task automatic csr_rd(input string tag, input bit [1:0] c, input bit [4:0] ix,
                        input logic [NE-1:0] p, output logic [63:0] v);
    tick(tag, p, 1'b1, 1'b0, c, ix, 64'd0, v);
  endtask

  task automatic check_defaults(input string tag);
    logic [63:0] v;
    for (int i = 0; i < NC; i++) begin
      csr_rd({tag, "_cnt"}, 2'd0, 5'(i), '0, v);
      check({tag, "_cnt_zero"}, v, 64'd0);
      csr_rd({tag, "_sel"}, 2'd1, 5'(i), '0, v);
      check({tag, "_sel_dflt"}, v, 64'(i % NE));
    end
    csr_rd({tag, "_ctrl"}, 2'd2, 5'd0, '0, v);
    check({tag, "_ctrl_dflt"}, v, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    csr_bus.req = 1'b0; csr_bus.we = 1'b0; csr_bus.cls = CNT;
    csr_bus.idx = '0; csr_bus.wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rdata", csr_bus.rdata, 64'd0);
    check("rst_rvalid", 64'(csr_bus.rvalid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check_defaults("rst");

    // Cycle event held high for 100 cycles.
    idle("cyc", 25'h1, 100);
    csr_rd("cyc", 2'd0, 5'd0, 25'h1, v);
    check("cyc_range", 64'(v >= 64'd99 && v <= 64'd101), 64'd1);

    // Counter 3 retargeted to event 5.
    csr_wr("sel_w", 2'd1, 5'd3, 64'd5, '0);
    csr_wr("sel_clr", 2'd0, 5'd3, 64'd0, '0);
    for (int k = 0; k < 7; k++) begin
      idle("sel_p5", 25'h20, 1);
      idle("sel_p3", 25'h8, 1);
    end
    idle("sel_gap", '0, 2);
    csr_rd("sel_rd", 2'd0, 5'd3, '0, v);
    check("sel_cnt7", v, 64'd7);

    // Wrap of counter 2 with its interrupt mask set.
    csr_wr("wrap_mask", 2'd3, 5'd0, 64'h0000_0004_0000_0000, '0);
    csr_wr("wrap_w", 2'd0, 5'd2, 64'hFE, '0);
    idle("wrap_evt", 25'h4, 2);
    idle("wrap_gap", '0, 3);
    csr_rd("wrap_rd", 2'd0, 5'd2, '0, v);
    check("wrap_zero", v, 64'd0);
    csr_rd("wrap_ovf", 2'd3, 5'd0, '0, v);
    check("wrap_ovf_bit", v, OVF_EN ? 64'h0000_0004_0000_0004 : 64'd0);
    check("wrap_irq_lvl", 64'(irq), 64'(OVF_EN));
    csr_wr("wrap_w1c", 2'd3, 5'd0, 64'h0000_0004_0000_0004, '0);
    idle("wrap_post", '0, 2);
    csr_rd("wrap_ovf2", 2'd3, 5'd0, '0, v);
    check("wrap_ovf_clr", v, OVF_EN ? 64'h0000_0004_0000_0000 : 64'd0);

    // CSR write collides with an increment; then inhibit counter 1.
    idle("col_evt", 25'h2, 3);
    csr_wr("col_w", 2'd0, 5'd1, 64'h10, 25'h2);
    csr_rd("col_rd", 2'd0, 5'd1, '0, v);
    check("col_wins", v, 64'h10);
    csr_wr("inh_w", 2'd2, 5'd0, 64'h5, '0);
    idle("inh_evt", 25'h3, 10);
    csr_rd("inh_c1", 2'd0, 5'd1, 25'h3, v);
    csr_rd("inh_c0", 2'd0, 5'd0, 25'h3, v);
    csr_rd("inh_ctrl", 2'd2, 5'd0, '0, v);
    csr_wr("inh_clr", 2'd2, 5'd0, 64'h1, '0);

    // Out-of-range selector and index.
    csr_wr("rng_sel", 2'd1, 5'd4, 64'd31, '0);
    csr_wr("rng_clr", 2'd0, 5'd4, 64'd0, '0);
    for (int k = 0; k < 20; k++) idle("rng_evt", NE'($urandom), 1);
    idle("rng_gap", '0, 2);
    csr_rd("rng_c4", 2'd0, 5'd4, '0, v);
    check("rng_nocount", v, 64'd0);
    csr_wr("rng_w12", 2'd0, 5'd12, {$urandom, $urandom}, '0);
    csr_rd("rng_r12", 2'd0, 5'd12, '0, v);
    check("rng_idx12", v, 64'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      tick("rnd", NE'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 11)), {$urandom, $urandom}, v);
    end

    // Reset lands in the cycle after a read request.
    pmu = '0;
    csr_bus.req = 1'b1; csr_bus.we = 1'b0; csr_bus.cls = CNT; csr_bus.idx = 5'd0;
    @(posedge clk);
    #1 rst = 1'b1;
    csr_bus.req = 1'b0;
    #1;
    check("mid_rvalid", 64'(csr_bus.rvalid), 64'd0);
    check("mid_rdata", csr_bus.rdata, 64'd0);
    check("mid_irq", 64'(irq), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_defaults("mid");
    idle("end", '0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
